// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a valid/ready output, plus framing, parity and overrun status.
// Optional parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_os #(
   parameter int unsigned CLK_FREQ   = 1000000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TW      = $clog2(OVERSAMPLE);

   localparam bit CFG_OK = (OVERSAMPLE >= 8) && (OVERSAMPLE <= 32) && (OVERSAMPLE % 2 == 0) &&
                           (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                           ((STOP_BITS == 1) || (STOP_BITS == 2)) && (PARITY_ODD <= 1);

   if (!CFG_OK) begin : g_bad_cfg
      $error("uart_rx_os: unsupported parameter set");
   end

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                 state_q, state_d;
   logic [DW-1:0]          div_q, div_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [3:0]             bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   fe_q, fe_d;
   logic                   sync1_q, sync2_q, prev_q;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;
   logic                   tick, fall, line, mid, done;
`ifdef UART_RX_PARITY_EN
   logic                   pe_q, pe_d;
   logic                   perr_q, perr_d;
`endif

   assign tick = (div_q == DW'(DIV - 1));
   assign div_d = tick ? '0 : div_q + 1'b1;
   assign line = sync2_q;
   assign fall = prev_q & ~sync2_q;
   assign mid  = tick && (tcnt_q == TW'(OVERSAMPLE - 1));

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      fe_d    = fe_q;
      done    = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d    = pe_q;
`endif
      if (state_q != IDLE && state_q != START && tick)
         tcnt_d = mid ? '0 : tcnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (fall) begin
               tcnt_d  = '0;
               bcnt_d  = '0;
               fe_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               if (tcnt_q == TW'(OVERSAMPLE / 2 - 1)) begin
                  tcnt_d  = '0;
                  state_d = line ? IDLE : DATA;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (mid) begin
               shreg_d = {line, shreg_q[DATA_BITS-1:1]};
               bcnt_d  = bcnt_q + 1'b1;
               if (bcnt_q == 4'(DATA_BITS - 1)) begin
                  bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (mid) begin
               pe_d    = ((^shreg_q) ^ line) != PARITY_ODD[0];
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (mid) begin
               if (!line) fe_d = 1'b1;
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == 4'(STOP_BITS - 1)) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A completion may load in the same cycle a pending word is taken.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = ferr_q;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_q;
`endif
      if (valid_q && rx_ready) valid_d = 1'b0;
      if (done) begin
         if (!valid_q || rx_ready) begin
            data_d  = shreg_q;
            ferr_d  = fe_q | ~line;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = pe_q;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         shreg_q <= '0;
         fe_q    <= 1'b0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_q    <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
         fe_q    <= fe_d;
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
         pe_q    <= pe_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver; successor to the single-rate shift receiver in the serial subsystem. It samples the asynchronous `rx` line at OVERSAMPLE ticks per bit and reads each bit at mid-bit. It supports 5–9 data bits, 1 or 2 stop bits and optional parity. Received words are delivered to the bus-side logic over a valid/ready handshake, with framing, parity and overrun status.

## Interface
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bits per second.
- OVERSAMPLE, 16: ticks per bit; even value, 8..32.
- DATA_BITS, 8: data bits per frame; 5..9.
- STOP_BITS, 1: stop bits checked; 1 or 2.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity. Used only under UART_RX_PARITY_EN.
- clk  in  1  system clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- rx  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  received word, LSB = first data bit on the line.
- rx_valid  out  1  rx_data and status are valid.
- rx_ready  in  1  consumer accepts the word.
- frame_err  out  1  a checked stop bit was 0; qualified by rx_valid.
- parity_err  out  1  parity mismatch; qualified by rx_valid.
- overrun  out  1  one-clk pulse: a completed frame was dropped.
- busy  out  1  FSM is not in IDLE.

## Operation
- Tick generator:
  - Divisor = max(1, CLK_FREQ/(BAUD_RATE*OVERSAMPLE)), integer floor.
  - Counter counts 0..divisor-1 and wraps; `tick` is high for one clk at the wrap.
- Input path:
  - `rx` passes through a 2-flop synchronizer; both flops reset to 1.
  - A third flop holds the previous synchronized value, for edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on the synchronized line (1 then 0) clears the tick-in-bit counter and the bit counter, then enters START. A line held low does not retrigger.
  - START: at tick index OVERSAMPLE/2-1, sample the line. If it is 1, this is a false start: go to IDLE. If it is 0, clear the tick counter and go to DATA.
  - DATA: at every OVERSAMPLE-th tick, sample (mid-bit) and shift right into the data register from the MSB. After DATA_BITS samples, go to PARITY if compiled in, else STOP.
  - PARITY: one mid-bit sample, XORed with the data bits. Error if the result ≠ PARITY_ODD.
  - STOP: STOP_BITS mid-bit samples. Any 0 sets frame_err for this frame. After the last sample, go to IDLE immediately; the remaining half-bit is absorbed by edge detection.
- Completion: at the last stop sample, the word and status are presented.
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in that cycle: rx_data, frame_err and parity_err load, and rx_valid=1 on the next clk.
  - Otherwise the new frame is dropped, the old word is held, and overrun=1 for one clk.
- Handshake:
  - A transfer happens when rx_valid and rx_ready are both high at a clk edge. rx_valid then clears, unless a completion loads a new word in the same cycle.
  - rx_data and status are stable while rx_valid=1.
- Frames with frame_err or parity_err are still delivered.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - FSM in IDLE; tick, bit and divider counters cleared.
- rst has priority over all other events. Asserting rst mid-frame aborts the frame, and no rx_valid results.
- Synchronizer latency is 2 clk; edge detection adds 1 clk.
- Sample points fall at tick OVERSAMPLE/2-1 of the start bit, then every OVERSAMPLE ticks.
- Latency from the last stop-bit mid-sample to rx_valid=1 is 1 clk.
- busy goes high 1 clk after the detected edge and low on the clk that rx_valid loads, or on a false start.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: the PARITY state exists, frames carry one parity bit after the data, parity_err is computed, and PARITY_ODD selects the polarity.
  - Undefined: no parity state or bit, and parity_err is tied 0.
  - The port list is identical in both cases.

## Test plan
All scenarios use CLK_FREQ=1536000, BAUD_RATE=9600, OVERSAMPLE=16, so the divisor is 10 and one bit is 160 clk. rx_ready=1 unless stated.
- 8N1 frame 0xA5 → one rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0, within 1530±20 clk of the start edge.
- Low glitch of 40 clk on an idle line → no rx_valid; busy falls about 80 clk after the edge; the next valid frame 0x3C is received correctly.
- Frame 0x3C with stop bit driven 0 → rx_valid=1, rx_data=0x3C, frame_err=1. The line is then held low for 2 frame times → no further rx_valid until a rising then falling edge.
- With UART_RX_PARITY_EN, even parity: 0x07 sent with parity bit 0 → parity_err=1; 0x07 with parity bit 1 → parity_err=0.
- rx_ready=0, frames 0x11 then 0x22 → rx_data stays 0x11, overrun pulses 1 clk at the 0x22 completion; raising rx_ready transfers 0x11 and rx_valid clears.
- rst asserted for 1 clk at the 4th data bit of a frame → all outputs are 0 on the next clk, no rx_valid for that frame; the following frame 0x5A is received correctly.
